// File: rtl/duck_hunt_pkg.sv
// Shared constants for the duck hunt sprite logic: FSM encoding, sprite shape,
// screen limits and colours.
package duck_hunt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ERASE  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_LATCH  = 3'd3,
        ST_DRAW   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int         SPRITE_LEN = 13;
    localparam logic [3:0] LAST_IDX   = 4'd12;

    localparam int X_MAX_DEFAULT = 159;
    localparam int Y_MAX_DEFAULT = 119;

    localparam logic [2:0] COLOUR_WHITE = 3'b111;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    // Duck pixel offsets relative to the head anchor; the body trails to the left.
    localparam logic signed [3:0] SPRITE_DX [SPRITE_LEN] = '{
        4'sd0, 4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd4, -4'sd5,
        -4'sd3, -4'sd3, -4'sd4, -4'sd4, -4'sd5, -4'sd5
    };
    localparam logic signed [3:0] SPRITE_DY [SPRITE_LEN] = '{
        4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0,
        4'sd1, -4'sd1, 4'sd2, -4'sd2, 4'sd3, -4'sd3
    };

endpackage

// File: rtl/sprite_offset_rom.sv
// Combinational pixel-offset lookup for a 13-pixel sprite; indices past the
// end of the sprite return (0,0).
module sprite_offset_rom
    import duck_hunt_pkg::*;
(
    input  logic [3:0]        idx,
    output logic signed [3:0] dx,
    output logic signed [3:0] dy
);

    always_comb begin
        dx = '0;
        dy = '0;
        for (int i = 0; i < SPRITE_LEN; i++) begin
            if (idx == 4'(i)) begin
                dx = SPRITE_DX[i];
                dy = SPRITE_DY[i];
            end
        end
    end

endmodule

// File: rtl/bird_sprite_plotter.sv
// Per-frame duck sequencer: erase the old sprite, advance the bird position,
// latch it, then draw the new sprite one clipped pixel per cycle.
//
// state  | meaning
// IDLE   | wait for frame_tick
// ERASE  | replot previous duck in background colour, idx 0..12
// UPDATE | one-cycle advance pulse to the position counter
// LATCH  | capture bird_x/bird_y/bird_valid
// DRAW   | plot duck at latched position, idx 0..12
// DONE   | one-cycle done pulse
module bird_sprite_plotter
    import duck_hunt_pkg::*;
#(
    parameter logic [2:0] BIRD_COLOUR = COLOUR_WHITE,
    parameter logic [2:0] BG_COLOUR   = COLOUR_BLACK,
    parameter int         X_MAX       = X_MAX_DEFAULT,
    parameter int         Y_MAX       = Y_MAX_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] bird_x,
    input  logic [6:0] bird_y,
    input  logic       bird_valid,
    output logic       advance,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic signed [8:0] X_LIM = 9'(X_MAX);
    localparam logic signed [8:0] Y_LIM = 9'(Y_MAX);

    state_t            state, state_next;
    logic [3:0]        idx;
    logic [7:0]        cur_x, old_x, base_x;
    logic [6:0]        cur_y, old_y, base_y;
    logic              cur_v, old_valid;
    logic signed [3:0] dx, dy;
    logic signed [8:0] px, py;
    logic              pix_phase, idx_step, clipped;

    sprite_offset_rom u_rom (
        .idx (idx),
        .dx  (dx),
        .dy  (dy)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (frame_tick) state_next = old_valid ? ST_ERASE : ST_UPDATE;
            ST_ERASE:  if (idx == LAST_IDX) state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_LATCH;
            ST_LATCH:  state_next = bird_valid ? ST_DRAW : ST_DONE;
            ST_DRAW:   if (idx == LAST_IDX) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign pix_phase = (state == ST_ERASE) || (state == ST_DRAW);
    assign idx_step  = pix_phase && (idx != LAST_IDX);

    // idx wraps to 0 on the last pixel so the next pixel phase starts clean.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            cur_v     <= 1'b0;
            old_x     <= '0;
            old_y     <= '0;
            old_valid <= 1'b0;
        end else begin
            idx <= idx_step ? idx + 4'd1 : 4'd0;
            if (state == ST_LATCH) begin
                cur_x <= bird_x;
                cur_y <= bird_y;
                cur_v <= bird_valid;
                if (!bird_valid) old_valid <= 1'b0;
            end
            if (state == ST_DRAW && idx == LAST_IDX) begin
                old_x     <= cur_x;
                old_y     <= cur_y;
                old_valid <= 1'b1;
            end
        end
    end

    assign base_x  = (state == ST_ERASE) ? old_x : cur_x;
    assign base_y  = (state == ST_ERASE) ? old_y : cur_y;
    assign px      = $signed({1'b0, base_x}) + $signed({{5{dx[3]}}, dx});
    assign py      = $signed({2'b00, base_y}) + $signed({{5{dy[3]}}, dy});
    assign clipped = (px < 9'sd0) || (px > X_LIM) || (py < 9'sd0) || (py > Y_LIM);

    always_comb begin
        plot    = 1'b0;
        x       = '0;
        y       = '0;
        colour  = BG_COLOUR;
        advance = (state == ST_UPDATE);
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        if (pix_phase) begin
            x      = px[7:0];
            y      = py[6:0];
            colour = (state == ST_ERASE) ? BG_COLOUR : BIRD_COLOUR;
            plot   = !clipped && ((state == ST_ERASE) || cur_v);
        end
    end

endmodule

// File: tb/tb_bird_sprite_plotter.sv
// Scoreboard bench for bird_sprite_plotter: each frame pushes its expected
// plot/advance/done events with cycle stamps; a negedge monitor pops and compares.
module tb_bird_sprite_plotter;

    localparam int EV_PIX  = 0;
    localparam int EV_ADV  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int cyc;
        int x;
        int y;
        int c;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] bird_x = '0;
    logic [6:0] bird_y = '0;
    logic       bird_valid = 1'b0;
    logic       advance, plot, busy, done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    ev_t q[$];

    // Model state: the duck currently on screen.
    bit  m_old_v = 1'b0;
    int  m_ox = 0;
    int  m_oy = 0;

    int DXT[13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
    int DYT[13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

    bird_sprite_plotter dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .bird_x     (bird_x),
        .bird_y     (bird_y),
        .bird_valid (bird_valid),
        .advance    (advance),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic got(input int kind, input int gx, input int gy, input int gc);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d actual=kind%0d (%0d,%0d) c%0d required=none",
                     cyc, kind, gx, gy, gc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.x != gx || e.y != gy || e.c != gc) begin
                failures++;
                $display("FAIL event actual=kind%0d cyc%0d (%0d,%0d) c%0d required=kind%0d cyc%0d (%0d,%0d) c%0d",
                         kind, cyc, gx, gy, gc, e.kind, e.cyc, e.x, e.y, e.c);
            end
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (plot)    got(EV_PIX, int'(x), int'(y), int'(colour));
            if (advance) got(EV_ADV, 0, 0, 0);
            if (done)    got(EV_DONE, 0, 0, 0);
        end
    end

    task automatic push(input int kind, input int c_at, input int px, input int py,
                        input int col, input int cut);
        ev_t e;
        if (c_at <= cut) begin
            e.kind = kind; e.cyc = c_at; e.x = px; e.y = py; e.c = col;
            q.push_back(e);
        end
    endtask

    task automatic push_sprite(input int base_cyc, input int ax, input int ay,
                               input int col, input int cut);
        int px, py;
        for (int i = 0; i < 13; i++) begin
            px = ax + DXT[i];
            py = ay + DYT[i];
            if (px >= 0 && px <= 159 && py >= 0 && py <= 119)
                push(EV_PIX, base_cyc + i, px, py, col, cut);
        end
    endtask

    // One frame: tick, optional ticks while busy (offsets t1/t2), optional reset at offset rst_at.
    task automatic frame(input int bx, input int by, input bit bv,
                         input int t1, input int t2, input int rst_at);
        int t0, e, d_off, cut;
        @(negedge clock);
        bird_x = 8'(bx); bird_y = 7'(by); bird_valid = bv;
        frame_tick = 1'b1;
        t0 = cyc;
        e = m_old_v ? 13 : 0;
        d_off = bv ? 16 + e : 3 + e;
        cut = (rst_at > 0) ? t0 + rst_at : t0 + 1000;
        if (m_old_v) push_sprite(t0 + 1, m_ox, m_oy, 0, cut);
        push(EV_ADV, t0 + 1 + e, 0, 0, 0, cut);
        if (bv) push_sprite(t0 + 3 + e, bx, by, 7, cut);
        push(EV_DONE, t0 + d_off, 0, 0, 0, cut);
        if (rst_at > 0) m_old_v = 1'b0;
        else if (bv) begin m_old_v = 1'b1; m_ox = bx; m_oy = by; end
        else m_old_v = 1'b0;

        for (int k = 1; k <= d_off + 4; k++) begin
            @(negedge clock);
            frame_tick = (k == t1 || k == t2);
            if (rst_at > 0 && k == rst_at) reset = 1'b1;
            if (rst_at > 0 && k == rst_at + 1) begin
                chk("plot_after_reset", int'(plot), 0);
                chk("busy_after_reset", int'(busy), 0);
                reset = 1'b0;
                break;
            end
        end
        frame_tick = 1'b0;
        chk("busy_idle_after_frame", int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_plot", int'(plot), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_advance", int'(advance), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clock);

        frame(10, 20, 1'b1, 0, 0, 0);   // first frame, no erase
        frame(11, 20, 1'b1, 0, 0, 0);   // erase at (10,20), draw at (11,20)
        frame(2, 0, 1'b1, 0, 0, 0);     // clipped draw: 4 pixels
        frame(30, 30, 1'b0, 0, 0, 0);   // erase clipped duck, bird invalid
        frame(50, 50, 1'b1, 5, 16, 0);  // no erase; ticks while busy and in DONE ignored
        frame(60, 30, 1'b1, 0, 0, 21);  // reset during DRAW idx 5
        frame(0, 0, 1'b0, 0, 0, 0);     // after reset: no erase, done at T+3
        frame(70, 40, 1'b1, 0, 0, 0);   // still no erase after invalid frame

        repeat (3) @(negedge clock);
        chk("leftover_events", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bird_sprite_plotter.md
# bird_sprite_plotter

Per-frame sprite sequencer between the bird position logic (`bird_counter`/`random`) and the `vga_adapter` pixel port. On each frame tick it:

- erases the previously drawn 13-pixel duck in the background colour;
- pulses the position update;
- latches the new position;
- draws the duck at that position, one pixel per cycle with screen clipping.

It replaces free-running per-bird plotting with a strict erase, update, draw ordering.

## Interface

Parameters:
- `BIRD_COLOUR`, default 3'b111: colour used when drawing.
- `BG_COLOUR`, default 3'b000: colour used when erasing.
- `X_MAX`, default 159: last visible column.
- `Y_MAX`, default 119: last visible row.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clock`  in  1  system clock (CLOCK_50).
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse from `frame_counter`.
- `bird_x`  in  8  bird anchor column (head/body pixel 0).
- `bird_y`  in  7  bird anchor row.
- `bird_valid`  in  1  bird alive/visible; sampled in LATCH.
- `advance`  out  1  one-cycle pulse; drives `bird_counter` enable.
- `x`  out  8  pixel column to `vga_adapter`.
- `y`  out  7  pixel row to `vga_adapter`.
- `colour`  out  3  pixel colour to `vga_adapter`.
- `plot`  out  1  write strobe to `vga_adapter`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in state DONE.

## Operation

- States:
  - IDLE: wait for `frame_tick`.
  - ERASE: pixel index `idx` 0..12.
  - UPDATE: `advance`=1 for 1 cycle.
  - LATCH: capture `bird_x`/`bird_y`/`bird_valid` into `cur_x`/`cur_y`/`cur_v`.
  - DRAW: `idx` 0..12.
  - DONE: `done`=1, then IDLE.
- Transitions:
  - IDLE with `frame_tick` goes to ERASE if `old_valid`=1, else UPDATE.
  - ERASE at `idx`=12 goes to UPDATE.
  - UPDATE goes to LATCH.
  - LATCH goes to DRAW if `bird_valid`=1, else DONE.
  - DRAW at `idx`=12 goes to DONE.
- `idx` resets to 0 on entry to ERASE and DRAW.
- Erase/draw position sources:
  - ERASE uses `old_x`/`old_y`.
  - On leaving DRAW, `old_x`/`old_y` are set to `cur_x`/`cur_y` and `old_valid` is set to 1.
  - LATCH with `bird_valid`=0 clears `old_valid`.
- Sprite offsets (dx,dy) for `idx` 0..12:
  - 0: (0,0), 1: (0,+1), 2: (-1,0), 3: (-2,0), 4: (-3,0)
  - 5: (-4,0), 6: (-5,0), 7: (-3,+1), 8: (-3,-1)
  - 9: (-4,+2), 10: (-4,-2), 11: (-5,+3), 12: (-5,-3)
- Arithmetic and clipping:
  - Pixel coordinates are computed in 9-bit signed.
  - A pixel is clipped if px<0, px>`X_MAX`, py<0 or py>`Y_MAX`.
  - A clipped pixel gives `plot`=0 that cycle; `idx` still advances, so the state duration is fixed.
- Outputs in ERASE/DRAW:
  - `x`/`y` carry the low bits of px/py.
  - `colour` is `BG_COLOUR` (ERASE) or `BIRD_COLOUR` (DRAW).
- Outputs in other states: `plot`=0, `x`=0, `y`=0, `colour`=`BG_COLOUR`.
- `frame_tick` while `busy`=1 is ignored; it is not queued.
- Reset mid-operation: next cycle is IDLE with `old_valid`=0 and every output at its reset value. Partially drawn pixels stay on screen.

## Timing

- Reset values: state IDLE, `idx`=0, `old_valid`=0, `plot`=0, `x`=0, `y`=0, `colour`=`BG_COLOUR`, `advance`=0, `busy`=0, `done`=0.
- All outputs are combinational from registered state, `idx` and latched positions. There is no combinational path from inputs to outputs.
- Tick sampled in IDLE at cycle T, with `old_valid`=1:
  - ERASE T+1..T+13
  - UPDATE T+14
  - LATCH T+15
  - DRAW T+16..T+28
  - DONE T+29
- Same tick with `old_valid`=0:
  - UPDATE T+1
  - LATCH T+2
  - DRAW T+3..T+15
  - DONE T+16
- `bird_counter` increments on the edge ending UPDATE, so LATCH sees the new `bird_x`.

## Structure

- Shared package `duck_hunt_pkg` holds:
  - state encoding constants;
  - sprite length 13;
  - offset constants;
  - `X_MAX`/`Y_MAX` defaults;
  - colour constants.
- One sub-module: `sprite_offset_rom`, combinational, `idx` (4b) in, signed dx/dy out. It is reusable for the hunter sprite.

## Test plan

1. **First frame, no erase.** After reset, set `bird_x`=10, `bird_y`=20, `bird_valid`=1, pulse `frame_tick` at T. Required:
   - `advance` at T+1;
   - 13 plots T+3..T+15, colour 111, first pixel (10,20) and last pixel (5,17);
   - `done` at T+16.
2. **Second frame.** Counter then at 11, pulse `frame_tick`. Required:
   - 13 plots colour 000 around (10,20);
   - `advance` at T+14;
   - 13 plots colour 111 around (11,20);
   - `done` at T+29.
3. **Clipping.** Bird at (2,0). Required:
   - exactly 4 plots, `idx` 0..3, at (2,0), (2,1), (1,0), (0,0);
   - DRAW still lasts 13 cycles.
4. **Invalid bird.** `bird_valid`=0 at LATCH. Required:
   - no DRAW plots;
   - `done` at T+3 (first frame);
   - the following tick performs no erase.
5. **Tick while busy.** `frame_tick` pulses while busy. Required:
   - ignored: exactly one `advance` and one `done` for the sequence;
   - no restart.
6. **Reset mid-draw.** `reset` asserted during DRAW `idx`=5. Required:
   - next cycle `plot`=0 and `busy`=0;
   - next tick starts directly in UPDATE (no erase).
